// File: rtl/tape_buffer_ctrl.sv
// tape_buffer_ctrl: captures a TAP/CSW download into SDRAM, validates the CSW header,
// and serves player reads through periodic rd_en slots.
module tape_buffer_ctrl #(
    parameter logic [7:0] TAP_IDX     = 8'd2,
    parameter logic [7:0] CSW_IDX     = 8'd3,
    parameter int         SLOT_PERIOD = 16,
    parameter int         SLOT_LEN    = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic        o_ioctl_wait,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [24:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_q,
    output logic        o_tape_download,
    output logic        o_tape_mode,
    output logic [24:0] o_tape_size,
    output logic        o_hdr_err,
    output logic        o_buff_rd_en,
    input  logic        i_buff_rd,
    input  logic [24:0] i_buff_addr,
    output logic [7:0]  o_buff_din
);
    localparam int CW = $clog2(SLOT_PERIOD);
    localparam logic [2:0] S_IDLE = 3'd0, S_WR = 3'd1, S_FIN = 3'd2,
                           S_SLOT = 3'd3, S_RD = 3'd4, S_END = 3'd5;

    logic [2:0]    r_state;
    logic          r_dl_q, r_pend;
    logic [CW-1:0] r_cnt, r_len;
    logic [24:0]   r_addr, r_raddr;
    logic [7:0]    r_wdata, r_h16, r_h17, r_h19;
    logic          w_rise, w_tick, w_csw_ok, w_len_done;
    logic [24:0]   w_end;

    assign w_rise     = i_ioctl_download && !r_dl_q &&
                        (i_ioctl_index == TAP_IDX || i_ioctl_index == CSW_IDX);
    assign w_tick     = !o_tape_download && r_cnt == '0;
    // Saturate so the top address never wraps the size back to zero
    assign w_end      = (&i_ioctl_addr) ? i_ioctl_addr : i_ioctl_addr + 25'd1;
    assign w_csw_ok   = o_tape_size >= 25'h20 && r_h16 == 8'h1A && r_h17 == 8'h01 && r_h19 == 8'h01;
    assign w_len_done = r_len >= CW'(SLOT_LEN - 1);

    assign o_mem_req   = r_state == S_WR || r_state == S_RD;
    assign o_mem_we    = r_state == S_WR;
    assign o_mem_addr  = r_state == S_RD ? r_raddr : r_addr;
    assign o_mem_wdata = r_wdata;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_dl_q          <= 1'b0;
            r_pend          <= 1'b0;
            r_cnt           <= '0;
            r_len           <= '0;
            r_addr          <= '0;
            r_raddr         <= '0;
            r_wdata         <= '0;
            r_h16           <= '0;
            r_h17           <= '0;
            r_h19           <= '0;
            o_ioctl_wait    <= 1'b0;
            o_tape_download <= 1'b0;
            o_tape_mode     <= 1'b0;
            o_tape_size     <= '0;
            o_hdr_err       <= 1'b0;
            o_buff_rd_en    <= 1'b0;
            o_buff_din      <= '0;
        end else begin
            r_dl_q <= i_ioctl_download;
            r_cnt  <= (o_tape_download || r_cnt == CW'(SLOT_PERIOD - 1)) ? '0 : r_cnt + 1'b1;
            if (w_tick) r_pend <= 1'b1;
            if (o_buff_rd_en && r_len != CW'(SLOT_LEN)) r_len <= r_len + 1'b1;
            if (w_rise) begin
                r_state         <= S_IDLE;
                r_pend          <= 1'b0;
                r_h16           <= '0;
                r_h17           <= '0;
                r_h19           <= '0;
                o_ioctl_wait    <= 1'b0;
                o_tape_download <= 1'b1;
                o_tape_mode     <= i_ioctl_index == TAP_IDX;
                o_tape_size     <= '0;
                o_hdr_err       <= 1'b0;
                o_buff_rd_en    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (o_tape_download) begin
                            if (!i_ioctl_download) r_state <= S_FIN;
                            else if (i_ioctl_wr) begin
                                r_addr       <= i_ioctl_addr;
                                r_wdata      <= i_ioctl_dout;
                                o_ioctl_wait <= 1'b1;
                                r_state      <= S_WR;
                                if (w_end > o_tape_size) o_tape_size <= w_end;
                                if (i_ioctl_addr == 25'h16) r_h16 <= i_ioctl_dout;
                                if (i_ioctl_addr == 25'h17) r_h17 <= i_ioctl_dout;
                                if (i_ioctl_addr == 25'h19) r_h19 <= i_ioctl_dout;
                            end
                        end else if (r_pend || w_tick) begin
                            r_pend       <= 1'b0;
                            r_len        <= '0;
                            o_buff_rd_en <= 1'b1;
                            r_state      <= S_SLOT;
                        end
                    end
                    S_WR: begin
                        if (i_mem_ack) begin
                            o_ioctl_wait <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    S_FIN: begin
                        o_tape_download <= 1'b0;
                        r_state         <= S_IDLE;
                        if (o_tape_mode ? o_tape_size < 25'd2 : !w_csw_ok) o_tape_size <= '0;
                        if (!o_tape_mode && !w_csw_ok) o_hdr_err <= 1'b1;
                    end
                    S_SLOT: begin
                        if (i_buff_rd) begin
                            r_raddr <= i_buff_addr;
                            r_state <= S_RD;
                        end else if (w_len_done) begin
                            o_buff_rd_en <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    S_RD: begin
                        if (i_mem_ack) begin
                            o_buff_din <= i_mem_q;
                            r_state    <= S_END;
                        end
                    end
                    S_END: begin
                        if (w_len_done) begin
                            o_buff_rd_en <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
